// File: rtl/brq_wb_port_arbiter.sv
// Writeback port arbiter: LSU, EX and a buffered FPU result path share one RF write port.
// Optional BRQ_WB_ARB_PERF_EN adds EX-stall and FIFO-full performance strobes.
module brq_wb_port_arbiter #(
  parameter int unsigned FifoDepth = 4,
  parameter int unsigned MaxWait   = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         lsu_we_i,
  input  logic [4:0]                   lsu_waddr_i,
  input  logic [31:0]                  lsu_wdata_i,
  input  logic                         lsu_fp_i,
  input  logic                         ex_valid_i,
  output logic                         ex_ready_o,
  input  logic [4:0]                   ex_waddr_i,
  input  logic [31:0]                  ex_wdata_i,
  input  logic                         ex_fp_i,
  input  logic                         fpu_valid_i,
  output logic                         fpu_ready_o,
  input  logic [4:0]                   fpu_waddr_i,
  input  logic [31:0]                  fpu_wdata_i,
  input  logic                         fpu_fp_i,
  output logic                         rf_we_o,
  output logic                         fp_rf_we_o,
  output logic [4:0]                   rf_waddr_o,
  output logic [31:0]                  rf_wdata_o,
  input  logic [4:0]                   hazard_addr_i,
  input  logic                         hazard_fp_i,
  output logic                         hazard_o,
  output logic [$clog2(FifoDepth):0]   fifo_count_o
`ifdef BRQ_WB_ARB_PERF_EN
  ,
  output logic                         perf_ex_stall_o,
  output logic                         perf_fifo_full_o
`endif
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned AgeW = 4;

  typedef struct packed {
    logic        fp;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GntNone,
    GntLsu,
    GntEx,
    GntFifo
  } gnt_e;

  wb_entry_t       mem_q [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [AgeW-1:0] age_q, age_d;

  logic            head_valid;
  logic            full;
  logic            aged;
  logic            push;
  logic            pop;
  gnt_e            gnt;
  wb_entry_t       win;
  logic            hazard_hit;
  logic [PtrW-1:0] slot_offs;

  assign head_valid = (count_q != '0);
  assign full       = (count_q == CntW'(FifoDepth));
  assign aged       = head_valid && (age_q == AgeW'(MaxWait));

  // Fixed priority; an aged FIFO head jumps ahead of EX but never ahead of LSU.
  always_comb begin
    gnt = GntNone;
    if (rst_i) begin
      gnt = GntNone;
    end else if (lsu_we_i) begin
      gnt = GntLsu;
    end else if (aged) begin
      gnt = GntFifo;
    end else if (ex_valid_i) begin
      gnt = GntEx;
    end else if (head_valid) begin
      gnt = GntFifo;
    end
  end

  always_comb begin
    win = '0;
    case (gnt)
      GntLsu: begin
        win.fp   = lsu_fp_i;
        win.addr = lsu_waddr_i;
        win.data = lsu_wdata_i;
      end
      GntEx: begin
        win.fp   = ex_fp_i;
        win.addr = ex_waddr_i;
        win.data = ex_wdata_i;
      end
      GntFifo: win = mem_q[rd_ptr_q];
      default: win = '0;
    endcase
  end

  assign rf_we_o     = (gnt != GntNone) & ~win.fp;
  assign fp_rf_we_o  = (gnt != GntNone) &  win.fp;
  assign rf_waddr_o  = win.addr;
  assign rf_wdata_o  = win.data;
  assign ex_ready_o  = (gnt == GntEx);
  assign fpu_ready_o = ~rst_i & ~full;

  assign push = fpu_valid_i & fpu_ready_o;
  assign pop  = (gnt == GntFifo);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q + CntW'(push) - CntW'(pop);
    age_d    = age_q;
    if (!head_valid || pop) begin
      age_d = '0;
    end else if (age_q != AgeW'(MaxWait)) begin
      age_d = age_q + AgeW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      age_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      age_q    <= age_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q].fp   <= fpu_fp_i;
      mem_q[wr_ptr_q].addr <= fpu_waddr_i;
      mem_q[wr_ptr_q].data <= fpu_wdata_i;
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    hazard_hit = 1'b0;
    slot_offs  = '0;
    for (int i = 0; i < FifoDepth; i++) begin
      slot_offs = PtrW'(i) - rd_ptr_q;
      if ((CntW'(slot_offs) < count_q) &&
          (mem_q[i].addr == hazard_addr_i) &&
          (mem_q[i].fp == hazard_fp_i)) begin
        hazard_hit = 1'b1;
      end
    end
  end

  assign hazard_o     = hazard_hit & ~rst_i;
  assign fifo_count_o = rst_i ? '0 : count_q;

`ifdef BRQ_WB_ARB_PERF_EN
  assign perf_ex_stall_o  = ~rst_i & ex_valid_i & ~ex_ready_o;
  assign perf_fifo_full_o = ~rst_i & full;
`endif

endmodule

// File: tb/tb_brq_wb_port_arbiter.sv
// Directed self-checking bench for brq_wb_port_arbiter with hand-computed expectations.
module tb_brq_wb_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lsu_we_i;
  logic [4:0]  lsu_waddr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_fp_i;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [4:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic        ex_fp_i;
  logic        fpu_valid_i;
  logic        fpu_ready_o;
  logic [4:0]  fpu_waddr_i;
  logic [31:0] fpu_wdata_i;
  logic        fpu_fp_i;
  logic        rf_we_o;
  logic        fp_rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [4:0]  hazard_addr_i;
  logic        hazard_fp_i;
  logic        hazard_o;
  logic [2:0]  fifo_count_o;
`ifdef BRQ_WB_ARB_PERF_EN
  logic        perf_ex_stall_o;
  logic        perf_fifo_full_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  brq_wb_port_arbiter #(.FifoDepth(4), .MaxWait(3)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .lsu_we_i      (lsu_we_i),
    .lsu_waddr_i   (lsu_waddr_i),
    .lsu_wdata_i   (lsu_wdata_i),
    .lsu_fp_i      (lsu_fp_i),
    .ex_valid_i    (ex_valid_i),
    .ex_ready_o    (ex_ready_o),
    .ex_waddr_i    (ex_waddr_i),
    .ex_wdata_i    (ex_wdata_i),
    .ex_fp_i       (ex_fp_i),
    .fpu_valid_i   (fpu_valid_i),
    .fpu_ready_o   (fpu_ready_o),
    .fpu_waddr_i   (fpu_waddr_i),
    .fpu_wdata_i   (fpu_wdata_i),
    .fpu_fp_i      (fpu_fp_i),
    .rf_we_o       (rf_we_o),
    .fp_rf_we_o    (fp_rf_we_o),
    .rf_waddr_o    (rf_waddr_o),
    .rf_wdata_o    (rf_wdata_o),
    .hazard_addr_i (hazard_addr_i),
    .hazard_fp_i   (hazard_fp_i),
    .hazard_o      (hazard_o),
    .fifo_count_o  (fifo_count_o)
`ifdef BRQ_WB_ARB_PERF_EN
    ,
    .perf_ex_stall_o  (perf_ex_stall_o),
    .perf_fifo_full_o (perf_fifo_full_o)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Let combinational outputs settle before sampling, well clear of the next edge.
  task automatic settle();
    #2;
  endtask

  task automatic idle();
    lsu_we_i    = 1'b0; lsu_waddr_i = '0; lsu_wdata_i = '0; lsu_fp_i = 1'b0;
    ex_valid_i  = 1'b0; ex_waddr_i  = '0; ex_wdata_i  = '0; ex_fp_i  = 1'b0;
    fpu_valid_i = 1'b0; fpu_waddr_i = '0; fpu_wdata_i = '0; fpu_fp_i = 1'b0;
  endtask

  task automatic lsu(input logic [4:0] a, input logic [31:0] d);
    lsu_we_i = 1'b1; lsu_waddr_i = a; lsu_wdata_i = d; lsu_fp_i = 1'b0;
  endtask

  task automatic ex(input logic [4:0] a, input logic [31:0] d);
    ex_valid_i = 1'b1; ex_waddr_i = a; ex_wdata_i = d; ex_fp_i = 1'b0;
  endtask

  task automatic fpu(input logic [4:0] a, input logic [31:0] d);
    fpu_valid_i = 1'b1; fpu_waddr_i = a; fpu_wdata_i = d; fpu_fp_i = 1'b1;
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    hazard_addr_i = 5'd0;
    hazard_fp_i   = 1'b0;
    tick(); tick();

    // Reset state, with an LSU request present that must not write
    lsu(5'd1, 32'h1111);
    settle();
    check_eq("rst_rf_we",   32'(rf_we_o),      32'd0);
    check_eq("rst_fp_we",   32'(fp_rf_we_o),   32'd0);
    check_eq("rst_fpu_rdy", 32'(fpu_ready_o),  32'd0);
    check_eq("rst_count",   32'(fifo_count_o), 32'd0);
    check_eq("rst_waddr",   32'(rf_waddr_o),   32'd0);
    tick();
    rst_i = 1'b0;
    idle();

    // 1: LSU beats EX; EX written the following cycle
    lsu(5'd5, 32'hAAAA);
    ex(5'd6, 32'h6666);
    settle();
    check_eq("t1_we0",    32'(rf_we_o),    32'd1);
    check_eq("t1_addr0",  32'(rf_waddr_o), 32'd5);
    check_eq("t1_data0",  rf_wdata_o,      32'hAAAA);
    check_eq("t1_exrdy0", 32'(ex_ready_o), 32'd0);
    tick();
    lsu_we_i = 1'b0;
    settle();
    check_eq("t1_addr1",  32'(rf_waddr_o), 32'd6);
    check_eq("t1_data1",  rf_wdata_o,      32'h6666);
    check_eq("t1_exrdy1", 32'(ex_ready_o), 32'd1);
    tick();
    idle();
    settle();
    check_eq("t1_idle_we",   32'(rf_we_o),    32'd0);
    check_eq("t1_idle_addr", 32'(rf_waddr_o), 32'd0);

    // x0 passes through unchanged
    ex(5'd0, 32'h55);
    settle();
    check_eq("x0_we",   32'(rf_we_o),    32'd1);
    check_eq("x0_addr", 32'(rf_waddr_o), 32'd0);
    check_eq("x0_data", rf_wdata_o,      32'h55);
    tick();
    idle();

    // 2: single FPU result, one-cycle latency, hazard only while buffered
    fpu(5'd3, 32'h3F800000);
    hazard_addr_i = 5'd3; hazard_fp_i = 1'b1;
    settle();
    check_eq("t2_rdy",      32'(fpu_ready_o), 32'd1);
    check_eq("t2_fpwe_pre", 32'(fp_rf_we_o),  32'd0);
    check_eq("t2_haz_pre",  32'(hazard_o),    32'd0);
    tick();
    idle();
    settle();
    check_eq("t2_fpwe",  32'(fp_rf_we_o),   32'd1);
    check_eq("t2_rfwe",  32'(rf_we_o),      32'd0);
    check_eq("t2_addr",  32'(rf_waddr_o),   32'd3);
    check_eq("t2_data",  rf_wdata_o,        32'h3F800000);
    check_eq("t2_count", 32'(fifo_count_o), 32'd1);
    check_eq("t2_haz",   32'(hazard_o),     32'd1);
    hazard_fp_i = 1'b0;
    settle();
    check_eq("t2_haz_int", 32'(hazard_o), 32'd0);
    hazard_fp_i = 1'b1;
    tick();
    settle();
    check_eq("t2_count_post", 32'(fifo_count_o), 32'd0);
    check_eq("t2_haz_post",   32'(hazard_o),     32'd0);
    check_eq("t2_fpwe_post",  32'(fp_rf_we_o),   32'd0);

    // 3: EX every cycle, aged head wins on the 4th cycle
    ex(5'd10, 32'h100);
    fpu(5'd7, 32'h77);
    settle();
    check_eq("t3_c0_rdy", 32'(ex_ready_o), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      fpu_valid_i = 1'b0;
      ex(5'(10 + k), 32'(32'h100 + k));
      settle();
      check_eq($sformatf("t3_c%0d_rdy", k), 32'(ex_ready_o), 32'd1);
      check_eq($sformatf("t3_c%0d_cnt", k), 32'(fifo_count_o), 32'd1);
    end
    tick();
    ex(5'd14, 32'h104);
    settle();
    check_eq("t3_c4_rdy",  32'(ex_ready_o),  32'd0);
    check_eq("t3_c4_fpwe", 32'(fp_rf_we_o),  32'd1);
    check_eq("t3_c4_addr", 32'(rf_waddr_o),  32'd7);
    check_eq("t3_c4_data", rf_wdata_o,       32'h77);
    tick();
    settle();
    check_eq("t3_c5_rdy",  32'(ex_ready_o),   32'd1);
    check_eq("t3_c5_addr", 32'(rf_waddr_o),   32'd14);
    check_eq("t3_c5_cnt",  32'(fifo_count_o), 32'd0);
    tick();
    idle();

    // 4: fill FIFO behind LSU, hold the 5th, then drain in order
    for (int k = 0; k < 4; k++) begin
      lsu(5'd2, 32'(k));
      fpu(5'(20 + k), 32'(32'h200 + k));
      settle();
      check_eq($sformatf("t4_p%0d_rdy", k), 32'(fpu_ready_o), 32'd1);
      tick();
    end
    fpu(5'd24, 32'h204);
    settle();
    check_eq("t4_full_cnt", 32'(fifo_count_o), 32'd4);
    check_eq("t4_full_rdy", 32'(fpu_ready_o),  32'd0);
    check_eq("t4_lsu_addr", 32'(rf_waddr_o),   32'd2);
    tick();
    lsu_we_i = 1'b0;
    settle();
    check_eq("t4_pop0_addr", 32'(rf_waddr_o),  32'd20);
    check_eq("t4_pop0_data", rf_wdata_o,       32'h200);
    check_eq("t4_pop0_rdy",  32'(fpu_ready_o), 32'd0);
    tick();
    settle();
    check_eq("t4_pop1_addr", 32'(rf_waddr_o),   32'd21);
    check_eq("t4_pop1_rdy",  32'(fpu_ready_o),  32'd1);
    check_eq("t4_pop1_cnt",  32'(fifo_count_o), 32'd3);
    tick();
    fpu_valid_i = 1'b0;
    settle();
    check_eq("t4_pop2_addr", 32'(rf_waddr_o),   32'd22);
    check_eq("t4_pop2_cnt",  32'(fifo_count_o), 32'd3);
    tick();
    settle();
    check_eq("t4_pop3_addr", 32'(rf_waddr_o), 32'd23);
    tick();
    settle();
    check_eq("t4_pop4_addr", 32'(rf_waddr_o),   32'd24);
    check_eq("t4_pop4_data", rf_wdata_o,        32'h204);
    check_eq("t4_pop4_cnt",  32'(fifo_count_o), 32'd1);
    tick();
    settle();
    check_eq("t4_empty_fpwe", 32'(fp_rf_we_o),   32'd0);
    check_eq("t4_empty_cnt",  32'(fifo_count_o), 32'd0);

    // 5: reset mid-operation discards buffered results
    lsu(5'd2, 32'h0);
    fpu(5'd8, 32'h8);
    tick();
    fpu(5'd9, 32'h9);
    tick();
    fpu_valid_i = 1'b0;
    hazard_addr_i = 5'd8; hazard_fp_i = 1'b1;
    settle();
    check_eq("t5_cnt_pre", 32'(fifo_count_o), 32'd2);
    check_eq("t5_haz_pre", 32'(hazard_o),     32'd1);
    tick();
    rst_i = 1'b1;
    settle();
    check_eq("t5_rst_cnt",  32'(fifo_count_o), 32'd0);
    check_eq("t5_rst_we",   32'(rf_we_o),      32'd0);
    check_eq("t5_rst_fpwe", 32'(fp_rf_we_o),   32'd0);
    check_eq("t5_rst_haz",  32'(hazard_o),     32'd0);
    tick();
    rst_i = 1'b0;
    idle();
    settle();
    check_eq("t5_post_cnt",  32'(fifo_count_o), 32'd0);
    check_eq("t5_post_fpwe", 32'(fp_rf_we_o),   32'd0);
    check_eq("t5_post_haz",  32'(hazard_o),     32'd0);
    tick();

    // 6: push and pop in the same cycle at count 2
    lsu(5'd2, 32'h0);
    fpu(5'd12, 32'hC);
    tick();
    fpu(5'd13, 32'hD);
    tick();
    lsu_we_i = 1'b0;
    fpu(5'd15, 32'hF);
    hazard_addr_i = 5'd12; hazard_fp_i = 1'b1;
    settle();
    check_eq("t6_cnt",  32'(fifo_count_o), 32'd2);
    check_eq("t6_fpwe", 32'(fp_rf_we_o),   32'd1);
    check_eq("t6_addr", 32'(rf_waddr_o),   32'd12);
    check_eq("t6_haz",  32'(hazard_o),     32'd1);
    check_eq("t6_rdy",  32'(fpu_ready_o),  32'd1);
    tick();
    fpu_valid_i = 1'b0;
    settle();
    check_eq("t6_cnt_after", 32'(fifo_count_o), 32'd2);
    check_eq("t6_addr1",     32'(rf_waddr_o),   32'd13);
    check_eq("t6_haz_gone",  32'(hazard_o),     32'd0);
    tick();
    settle();
    check_eq("t6_addr2", 32'(rf_waddr_o),   32'd15);
    check_eq("t6_cnt2",  32'(fifo_count_o), 32'd1);
    tick();
    settle();
    check_eq("t6_cnt3", 32'(fifo_count_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
